// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write controller.
// wb_entry_t is one queued writeback: target address, data byte and the
// addressing mode (func = 1 addressed write, func = 0 write to ACC_REG).
package rf_pkg;

    localparam int RF_RAW  = 4;
    localparam int ACC_REG = 1;
    localparam int DATA_W  = 8;

    typedef struct packed {
        logic [RF_RAW-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              func;
    } wb_entry_t;

    // Register actually written by an entry: its own address, or the
    // accumulator register when the entry is an implicit-target write.
    function automatic logic [RF_RAW-1:0] eff_target(input wb_entry_t e);
        return e.func ? e.addr : RF_RAW'(ACC_REG);
    endfunction

endpackage

// File: rtl/rf_write_ctrl_wb_fifo.sv
// wb_fifo: writeback queue storage for rf_write_ctrl.
// DEPTH entries of wb_entry_t, two push slots per cycle (slot 0 is the
// older of the two), one pop per cycle. Pointers wrap modulo DEPTH, which
// must be a power of two. The caller guarantees no overflow/underflow.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push0_en,
    input  wb_entry_t               push0_entry,
    input  logic                    push1_en,
    input  wb_entry_t               push1_entry,
    input  logic                    pop_en,
    output wb_entry_t [DEPTH-1:0]   mem_o,
    output logic [PTR_W-1:0]        rd_ptr_o,
    output logic [CNT_W-1:0]        count_o
);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      wr_ptr_slot1;

    // Slot 1 lands right after slot 0 when both push, otherwise at the tail.
    assign wr_ptr_slot1 = wr_ptr_q + PTR_W'(push0_en);

    // Storage, pointers and occupancy; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push0_en) begin
                mem_q[wr_ptr_q] <= push0_entry;
            end
            if (push1_en) begin
                mem_q[wr_ptr_slot1] <= push1_entry;
            end
            wr_ptr_q <= wr_ptr_q + PTR_W'(push0_en) + PTR_W'(push1_en);
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push0_en) + CNT_W'(push1_en) - CNT_W'(pop_en);
        end
    end

    assign mem_o    = mem_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl: merges ALU and load writeback requests into one queue and
// drains it into the register file at one write per cycle (stalled by
// hold_i). Also reports whether a queued write targets the register decode
// is reading.
// Optional feature: define RF_WRITE_CTRL_FWD_EN to build forwarding of the
// youngest matching queued data on fwd_data_o; otherwise fwd_data_o is 0.
// Queue entries carry RF_RAW-bit addresses; raw is expected to match RF_RAW.
module rf_write_ctrl
    import rf_pkg::*;
#(
    parameter int raw   = RF_RAW,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [raw-1:0]   alu_addr_i,
    input  logic [7:0]       alu_data_i,
    input  logic             alu_func_i,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic [raw-1:0]   mem_addr_i,
    input  logic [7:0]       mem_data_i,
    input  logic             mem_func_i,
    input  logic             hold_i,
    output logic             wen_o,
    output logic [raw-1:0]   rt_addr_o,
    output logic [7:0]       write_data_o,
    output logic             func_o,
    input  logic [raw-1:0]   chk_addr_i,
    output logic             chk_hit_o,
    output logic [7:0]       fwd_data_o,
    output logic [CNT_W-1:0] pending_o
);

    wb_entry_t [DEPTH-1:0] q_mem;
    logic [PTR_W-1:0]      q_rd_ptr;
    logic [CNT_W-1:0]      q_count;

    wb_entry_t             alu_entry;
    wb_entry_t             mem_entry;
    wb_entry_t             push0_entry;
    wb_entry_t             push1_entry;
    wb_entry_t             head;
    logic                  alu_acc;
    logic                  mem_acc;
    logic                  push0_en;
    logic                  push1_en;
    logic                  q_empty;
    logic [RF_RAW-1:0]     chk_tgt;
    logic [PTR_W-1:0]      hit_idx;

    assign alu_entry = '{addr: RF_RAW'(alu_addr_i), data: alu_data_i, func: alu_func_i};
    assign mem_entry = '{addr: RF_RAW'(mem_addr_i), data: mem_data_i, func: mem_func_i};
    assign q_empty   = (q_count == '0);
    assign chk_tgt   = RF_RAW'(chk_addr_i);

    // Ready from pre-pop occupancy; the load path keeps the last free slot.
    always_comb begin
        alu_ready_o = (q_count <= CNT_W'(DEPTH - 2));
        mem_ready_o = (q_count <= CNT_W'(DEPTH - 1));
        alu_acc     = alu_valid_i && alu_ready_o;
        mem_acc     = mem_valid_i && mem_ready_o;
    end

    // Push slot mapping: a load request is always queued ahead of an ALU one.
    always_comb begin
        push0_en    = mem_acc || alu_acc;
        push0_entry = mem_acc ? mem_entry : alu_entry;
        push1_en    = mem_acc && alu_acc;
        push1_entry = alu_entry;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .reset       (reset),
        .push0_en    (push0_en),
        .push0_entry (push0_entry),
        .push1_en    (push1_en),
        .push1_entry (push1_entry),
        .pop_en      (wen_o),
        .mem_o       (q_mem),
        .rd_ptr_o    (q_rd_ptr),
        .count_o     (q_count)
    );

    // Drain side: present the head entry, zeroed while the queue is empty.
    always_comb begin
        wen_o        = !q_empty && !hold_i;
        head         = q_empty ? '0 : q_mem[q_rd_ptr];
        rt_addr_o    = raw'(head.addr);
        write_data_o = head.data;
        func_o       = head.func;
    end

    assign pending_o = q_count;

    // Hazard detect: any live entry whose effective target is the checked register.
    always_comb begin
        chk_hit_o = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_idx = q_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < q_count) && (eff_target(q_mem[hit_idx]) == chk_tgt)) begin
                chk_hit_o = 1'b1;
            end
        end
    end

`ifdef RF_WRITE_CTRL_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Forwarding: scan oldest to youngest so the youngest match is kept.
    always_comb begin
        fwd_data_o = '0;
        fwd_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = q_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < q_count) && (eff_target(q_mem[fwd_idx]) == chk_tgt)) begin
                fwd_data_o = q_mem[fwd_idx].data;
            end
        end
    end
`else
    assign fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Self-checking bench for rf_write_ctrl: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_rf_write_ctrl;

    localparam int RAW   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid_i, alu_ready_o, alu_func_i;
    logic [RAW-1:0]  alu_addr_i;
    logic [7:0]      alu_data_i;
    logic            mem_valid_i, mem_ready_o, mem_func_i;
    logic [RAW-1:0]  mem_addr_i;
    logic [7:0]      mem_data_i;
    logic            hold_i;
    logic            wen_o, func_o, chk_hit_o;
    logic [RAW-1:0]  rt_addr_o, chk_addr_i;
    logic [7:0]      write_data_o, fwd_data_o;
    logic [CW-1:0]   pending_o;

    rf_write_ctrl #(.raw(RAW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_addr_i   (alu_addr_i),
        .alu_data_i   (alu_data_i),
        .alu_func_i   (alu_func_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .mem_func_i   (mem_func_i),
        .hold_i       (hold_i),
        .wen_o        (wen_o),
        .rt_addr_o    (rt_addr_o),
        .write_data_o (write_data_o),
        .func_o       (func_o),
        .chk_addr_i   (chk_addr_i),
        .chk_hit_o    (chk_hit_o),
        .fwd_data_o   (fwd_data_o),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RAW-1:0] addr;
        logic [7:0]     data;
        logic           func;
    } ent_t;

    ent_t ref_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs follow directly from the queue contents and current inputs.
    task automatic check_outputs();
        int             cnt;
        logic           e_hit;
        logic [7:0]     e_fwd;
        logic [RAW-1:0] tgt;
        cnt   = ref_q.size();
        e_hit = 1'b0;
        e_fwd = 8'h00;
        foreach (ref_q[i]) begin
            tgt = ref_q[i].func ? ref_q[i].addr : RAW'(1);
            if (tgt == chk_addr_i) begin
                e_hit = 1'b1;
                e_fwd = ref_q[i].data;
            end
        end
`ifndef RF_WRITE_CTRL_FWD_EN
        e_fwd = 8'h00;
`endif
        check_eq("pending", 32'(pending_o), 32'(cnt));
        check_eq("alu_ready", 32'(alu_ready_o), 32'(cnt <= DEPTH - 2));
        check_eq("mem_ready", 32'(mem_ready_o), 32'(cnt <= DEPTH - 1));
        check_eq("wen", 32'(wen_o), 32'((cnt != 0) && !hold_i));
        check_eq("rt_addr", 32'(rt_addr_o), (cnt != 0) ? 32'(ref_q[0].addr) : 32'd0);
        check_eq("wdata", 32'(write_data_o), (cnt != 0) ? 32'(ref_q[0].data) : 32'd0);
        check_eq("func", 32'(func_o), (cnt != 0) ? 32'(ref_q[0].func) : 32'd0);
        check_eq("chk_hit", 32'(chk_hit_o), 32'(e_hit));
        check_eq("fwd_data", 32'(fwd_data_o), 32'(e_fwd));
    endtask

    // One clock: check (optional), then advance the model on the edge.
    task automatic tick(input bit chk);
        bit acc_mem, acc_alu, pop;
        #1;
        if (chk) check_outputs();
        acc_mem = mem_valid_i && (ref_q.size() <= DEPTH - 1);
        acc_alu = alu_valid_i && (ref_q.size() <= DEPTH - 2);
        pop     = (ref_q.size() != 0) && !hold_i;
        @(posedge clk);
        if (reset) begin
            ref_q.delete();
        end else begin
            if (pop) void'(ref_q.pop_front());
            if (acc_mem) ref_q.push_back('{mem_addr_i, mem_data_i, mem_func_i});
            if (acc_alu) ref_q.push_back('{alu_addr_i, alu_data_i, alu_func_i});
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        alu_valid_i = 1'b0; alu_addr_i = '0; alu_data_i = '0; alu_func_i = 1'b0;
        mem_valid_i = 1'b0; mem_addr_i = '0; mem_data_i = '0; mem_func_i = 1'b0;
    endtask

    task automatic set_alu(input logic [RAW-1:0] a, input logic [7:0] d, input logic f);
        alu_valid_i = 1'b1; alu_addr_i = a; alu_data_i = d; alu_func_i = f;
    endtask

    task automatic set_mem(input logic [RAW-1:0] a, input logic [7:0] d, input logic f);
        mem_valid_i = 1'b1; mem_addr_i = a; mem_data_i = d; mem_func_i = f;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before bound");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        reset = 1'b1; hold_i = 1'b0; chk_addr_i = '0;
        tick(0);
        tick(1);                                  // reset state
        reset = 1'b0;
        tick(1);

        // Single ALU push, one-cycle latency
        set_alu(4'd5, 8'h3C, 1'b1);
        tick(1);
        idle_in();
        #1;
        check_eq("r028_wen", 32'(wen_o), 32'd1);
        check_eq("r028_addr", 32'(rt_addr_o), 32'd5);
        check_eq("r028_data", 32'(write_data_o), 32'h3C);
        tick(1);
        #1;
        check_eq("r028_pending", 32'(pending_o), 32'd0);
        tick(1);

        // Dual push: mem first, then ALU
        set_mem(4'd7, 8'hA1, 1'b1);
        set_alu(4'd9, 8'hB2, 1'b1);
        tick(1);
        idle_in();
        #1;
        check_eq("r029_first", 32'(write_data_o), 32'hA1);
        tick(1);
        #1;
        check_eq("r029_second", 32'(write_data_o), 32'hB2);
        tick(1);

        // Fill under hold: DEPTH-1 then full
        hold_i = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_mem(RAW'(i + 2), 8'(8'h40 + i), 1'b1);
            tick(1);
        end
        idle_in();
        #1;
        check_eq("r029_alu_rdy_low", 32'(alu_ready_o), 32'd0);
        check_eq("r029_mem_rdy_high", 32'(mem_ready_o), 32'd1);
        set_mem(4'd14, 8'h4F, 1'b1);
        set_alu(4'd15, 8'hEE, 1'b1);
        tick(1);
        idle_in();
        #1;
        check_eq("r030_full_alu", 32'(alu_ready_o), 32'd0);
        check_eq("r030_full_mem", 32'(mem_ready_o), 32'd0);
        check_eq("r030_full_wen", 32'(wen_o), 32'd0);
        tick(1);
        hold_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) tick(1);

        // Implicit-target entry then addressed entry to register 1
        hold_i = 1'b1;
        chk_addr_i = 4'd1;
        set_alu(4'd7, 8'h11, 1'b0);
        tick(1);
        set_alu(4'd1, 8'h22, 1'b1);
        tick(1);
        idle_in();
        #1;
        check_eq("r031_hit", 32'(chk_hit_o), 32'd1);
`ifdef RF_WRITE_CTRL_FWD_EN
        check_eq("r031_fwd", 32'(fwd_data_o), 32'h22);
`else
        check_eq("r031_fwd", 32'(fwd_data_o), 32'h00);
`endif
        tick(1);

        // Reset with 3 entries queued and requests pending
        set_mem(4'd3, 8'h33, 1'b1);
        tick(1);
        set_mem(4'd4, 8'h44, 1'b1);
        set_alu(4'd6, 8'h66, 1'b1);
        reset = 1'b1;
        hold_i = 1'b0;
        tick(1);
        reset = 1'b0;
        idle_in();
        #1;
        check_eq("r032_pending", 32'(pending_o), 32'd0);
        check_eq("r032_wen", 32'(wen_o), 32'd0);
        tick(1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            alu_valid_i = 1'($urandom_range(0, 1));
            alu_addr_i  = RAW'($urandom_range(0, 15));
            alu_data_i  = 8'($urandom_range(0, 255));
            alu_func_i  = 1'($urandom_range(0, 1));
            mem_valid_i = 1'($urandom_range(0, 1));
            mem_addr_i  = RAW'($urandom_range(0, 15));
            mem_data_i  = 8'($urandom_range(0, 255));
            mem_func_i  = 1'($urandom_range(0, 1));
            hold_i      = ($urandom_range(0, 9) < 3);
            reset       = ($urandom_range(0, 199) == 0);
            chk_addr_i  = ($urandom_range(0, 2) == 0) ? RAW'(1) : RAW'($urandom_range(0, 15));
            tick(1);
        end
        reset = 1'b0;
        idle_in();
        hold_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
